// File: rtl/superh16_pkg.sv
// -----------------------------------------------------------------------------
// superh16_pkg
// Shared sizing and types for the SuperH16 register-rename stage.
//   ISSUE_WIDTH    : instructions renamed per group
//   RETIRE_WIDTH   : instructions committed per cycle
//   NUM_ARCH_REGS  : architectural register count (r0 is hard-wired)
//   ARCH_REG_BITS  : architectural register index width
//   PHYS_REG_BITS  : physical register index width
//   rename_slot_t  : one renamed slot as held in the output stage
// -----------------------------------------------------------------------------
package superh16_pkg;

    localparam int ISSUE_WIDTH   = 2;
    localparam int RETIRE_WIDTH  = 2;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ARCH_REG_BITS = 5;
    localparam int PHYS_REG_BITS = 7;

    typedef logic [ARCH_REG_BITS-1:0] arch_reg_t;
    typedef logic [PHYS_REG_BITS-1:0] phys_reg_t;

    typedef struct packed {
        logic      valid;
        logic      rd_valid;
        phys_reg_t prd;
        phys_reg_t old_prd;
        phys_reg_t prs1;
        phys_reg_t prs2;
    } rename_slot_t;

endpackage

// File: rtl/superh16_rat_bypass.sv
// -----------------------------------------------------------------------------
// superh16_rat_bypass
// Combinational intra-group resolution of source operands and the previous
// destination mapping. Each slot starts from its speculative-map lookup and is
// overridden by the grant of the youngest older slot in the same group that
// writes the same architectural register.
//   i_writing        : per-slot "writes a non-zero rd" flag
//   i_rd/i_rs1/i_rs2 : architectural register indices per slot
//   i_map_*          : speculative-map lookups for those indices
//   i_grant          : free-list grant per slot
//   o_prs1/o_prs2    : resolved physical sources
//   o_old_prd        : resolved prior mapping of rd
// -----------------------------------------------------------------------------
module superh16_rat_bypass
    import superh16_pkg::*;
(
    input  logic [ISSUE_WIDTH-1:0] i_writing,
    input  arch_reg_t              i_rd      [ISSUE_WIDTH],
    input  arch_reg_t              i_rs1     [ISSUE_WIDTH],
    input  arch_reg_t              i_rs2     [ISSUE_WIDTH],
    input  phys_reg_t              i_map_rd  [ISSUE_WIDTH],
    input  phys_reg_t              i_map_rs1 [ISSUE_WIDTH],
    input  phys_reg_t              i_map_rs2 [ISSUE_WIDTH],
    input  phys_reg_t              i_grant   [ISSUE_WIDTH],
    output phys_reg_t              o_prs1    [ISSUE_WIDTH],
    output phys_reg_t              o_prs2    [ISSUE_WIDTH],
    output phys_reg_t              o_old_prd [ISSUE_WIDTH]
);

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            o_prs1[i]    = i_map_rs1[i];
            o_prs2[i]    = i_map_rs2[i];
            o_old_prd[i] = i_map_rd[i];
            // Scan older slots oldest-first so the youngest match is applied
            // last. A writing slot never has rd=0, so r0 sources keep map[0].
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if (j < i && i_writing[j]) begin
                    if (i_rd[j] == i_rs1[i]) o_prs1[i]    = i_grant[j];
                    if (i_rd[j] == i_rs2[i]) o_prs2[i]    = i_grant[j];
                    if (i_rd[j] == i_rd[i])  o_old_prd[i] = i_grant[j];
                end
            end
        end
    end

endmodule

// File: rtl/superh16_rename_map.sv
// -----------------------------------------------------------------------------
// superh16_rename_map
// Register alias table with a speculative map (updated on rename) and a
// committed map (updated at retire). Flush restores the speculative map from
// the committed map. Renamed groups are held in a one-deep registered output
// stage with valid/ready handshake.
//   clk, rst                 : clock, synchronous active-high reset
//   dec_*                    : decoded group in; dec_ready = group accepted
//   fl_alloc_valid/phys/succ : free-list request and grants, one per slot
//   ren_*                    : renamed group out; ren_ready from downstream
//   commit_valid/rd/prd      : retiring mappings for the committed map
//   flush                    : squash in-flight rename state
// -----------------------------------------------------------------------------
module superh16_rename_map
    import superh16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ISSUE_WIDTH-1:0]   dec_valid,
    input  logic [ISSUE_WIDTH-1:0]   dec_rd_valid,
    input  logic [ARCH_REG_BITS-1:0] dec_rd            [ISSUE_WIDTH],
    input  logic [ARCH_REG_BITS-1:0] dec_rs1           [ISSUE_WIDTH],
    input  logic [ARCH_REG_BITS-1:0] dec_rs2           [ISSUE_WIDTH],
    output logic                     dec_ready,
    output logic [ISSUE_WIDTH-1:0]   fl_alloc_valid,
    input  logic [PHYS_REG_BITS-1:0] fl_alloc_phys_reg [ISSUE_WIDTH],
    input  logic [ISSUE_WIDTH-1:0]   fl_alloc_success,
    output logic [ISSUE_WIDTH-1:0]   ren_valid,
    output logic [PHYS_REG_BITS-1:0] ren_prd           [ISSUE_WIDTH],
    output logic [PHYS_REG_BITS-1:0] ren_old_prd       [ISSUE_WIDTH],
    output logic [PHYS_REG_BITS-1:0] ren_prs1          [ISSUE_WIDTH],
    output logic [PHYS_REG_BITS-1:0] ren_prs2          [ISSUE_WIDTH],
    output logic [ISSUE_WIDTH-1:0]   ren_rd_valid,
    input  logic                     ren_ready,
    input  logic [RETIRE_WIDTH-1:0]  commit_valid,
    input  logic [ARCH_REG_BITS-1:0] commit_rd         [RETIRE_WIDTH],
    input  logic [PHYS_REG_BITS-1:0] commit_prd        [RETIRE_WIDTH],
    input  logic                     flush
);

    phys_reg_t    r_spec_map     [NUM_ARCH_REGS];
    phys_reg_t    r_commit_map   [NUM_ARCH_REGS];
    phys_reg_t    w_commit_next  [NUM_ARCH_REGS];
    rename_slot_t r_ren          [ISSUE_WIDTH];

    logic [ISSUE_WIDTH-1:0] w_writing;
    logic                   w_out_free;
    logic                   w_grants_ok;
    logic                   w_accept;

    phys_reg_t w_map_rd  [ISSUE_WIDTH];
    phys_reg_t w_map_rs1 [ISSUE_WIDTH];
    phys_reg_t w_map_rs2 [ISSUE_WIDTH];
    phys_reg_t w_prs1    [ISSUE_WIDTH];
    phys_reg_t w_prs2    [ISSUE_WIDTH];
    phys_reg_t w_old_prd [ISSUE_WIDTH];

    // Output stage can take a new group when empty or being drained now.
    assign w_out_free  = ~(|ren_valid) | ren_ready;
    // Every writing slot needs its grant; the group is all-or-nothing.
    assign w_grants_ok = &(~w_writing | fl_alloc_success);
    assign dec_ready   = w_out_free & w_grants_ok & ~flush & ~rst;
    assign w_accept    = dec_ready;

    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
        // Writes to r0 are dropped so r0 stays pinned to phys 0.
        assign w_writing[gi]      = dec_valid[gi] & dec_rd_valid[gi] & (dec_rd[gi] != '0);
        assign fl_alloc_valid[gi] = w_writing[gi] & w_out_free & ~flush & ~rst;

        assign w_map_rd[gi]  = r_spec_map[dec_rd[gi]];
        assign w_map_rs1[gi] = r_spec_map[dec_rs1[gi]];
        assign w_map_rs2[gi] = r_spec_map[dec_rs2[gi]];

        assign ren_valid[gi]    = r_ren[gi].valid;
        assign ren_rd_valid[gi] = r_ren[gi].rd_valid;
        assign ren_prd[gi]      = r_ren[gi].prd;
        assign ren_old_prd[gi]  = r_ren[gi].old_prd;
        assign ren_prs1[gi]     = r_ren[gi].prs1;
        assign ren_prs2[gi]     = r_ren[gi].prs2;
    end

    superh16_rat_bypass u_bypass (
        .i_writing (w_writing),
        .i_rd      (dec_rd),
        .i_rs1     (dec_rs1),
        .i_rs2     (dec_rs2),
        .i_map_rd  (w_map_rd),
        .i_map_rs1 (w_map_rs1),
        .i_map_rs2 (w_map_rs2),
        .i_grant   (fl_alloc_phys_reg),
        .o_prs1    (w_prs1),
        .o_prs2    (w_prs2),
        .o_old_prd (w_old_prd)
    );

    // Committed map after this cycle's retirements; a flush in the same cycle
    // must see these updates, so they are formed combinationally.
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            w_commit_next[r] = r_commit_map[r];
        end
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (commit_valid[k] && commit_rd[k] != '0) begin
                w_commit_next[commit_rd[k]] = commit_prd[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                r_spec_map[r]   <= phys_reg_t'(r);
                r_commit_map[r] <= phys_reg_t'(r);
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                r_ren[i] <= '0;
            end
        end else begin
            r_commit_map <= w_commit_next;
            if (flush) begin
                r_spec_map <= w_commit_next;
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    r_ren[i].valid <= 1'b0;
                end
            end else if (w_accept) begin
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    // Ascending slot order: the youngest writer of an rd wins.
                    if (w_writing[i]) begin
                        r_spec_map[dec_rd[i]] <= fl_alloc_phys_reg[i];
                    end
                    r_ren[i] <= '{
                        valid:    dec_valid[i],
                        rd_valid: w_writing[i],
                        prd:      w_writing[i] ? fl_alloc_phys_reg[i] : '0,
                        old_prd:  w_writing[i] ? w_old_prd[i] : '0,
                        prs1:     w_prs1[i],
                        prs2:     w_prs2[i]
                    };
                end
            end else if (ren_ready) begin
                // Group drained with nothing new accepted behind it.
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    r_ren[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_superh16_rename_map.sv
// -----------------------------------------------------------------------------
// tb_superh16_rename_map
// Directed stimulus for the rename map. Each accepted group pushes its
// hand-computed renamed slots into a scoreboard; a monitor pops and compares
// whenever the DUT hands a group downstream.
// -----------------------------------------------------------------------------
module tb_superh16_rename_map;
    import superh16_pkg::*;

    logic                     clk;
    logic                     rst;
    logic [ISSUE_WIDTH-1:0]   dec_valid;
    logic [ISSUE_WIDTH-1:0]   dec_rd_valid;
    logic [ARCH_REG_BITS-1:0] dec_rd            [ISSUE_WIDTH];
    logic [ARCH_REG_BITS-1:0] dec_rs1           [ISSUE_WIDTH];
    logic [ARCH_REG_BITS-1:0] dec_rs2           [ISSUE_WIDTH];
    logic                     dec_ready;
    logic [ISSUE_WIDTH-1:0]   fl_alloc_valid;
    logic [PHYS_REG_BITS-1:0] fl_alloc_phys_reg [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]   fl_alloc_success;
    logic [ISSUE_WIDTH-1:0]   ren_valid;
    logic [PHYS_REG_BITS-1:0] ren_prd           [ISSUE_WIDTH];
    logic [PHYS_REG_BITS-1:0] ren_old_prd       [ISSUE_WIDTH];
    logic [PHYS_REG_BITS-1:0] ren_prs1          [ISSUE_WIDTH];
    logic [PHYS_REG_BITS-1:0] ren_prs2          [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]   ren_rd_valid;
    logic                     ren_ready;
    logic [RETIRE_WIDTH-1:0]  commit_valid;
    logic [ARCH_REG_BITS-1:0] commit_rd         [RETIRE_WIDTH];
    logic [PHYS_REG_BITS-1:0] commit_prd        [RETIRE_WIDTH];
    logic                     flush;

    superh16_rename_map dut (
        .clk               (clk),
        .rst               (rst),
        .dec_valid         (dec_valid),
        .dec_rd_valid      (dec_rd_valid),
        .dec_rd            (dec_rd),
        .dec_rs1           (dec_rs1),
        .dec_rs2           (dec_rs2),
        .dec_ready         (dec_ready),
        .fl_alloc_valid    (fl_alloc_valid),
        .fl_alloc_phys_reg (fl_alloc_phys_reg),
        .fl_alloc_success  (fl_alloc_success),
        .ren_valid         (ren_valid),
        .ren_prd           (ren_prd),
        .ren_old_prd       (ren_old_prd),
        .ren_prs1          (ren_prs1),
        .ren_prs2          (ren_prs2),
        .ren_rd_valid      (ren_rd_valid),
        .ren_ready         (ren_ready),
        .commit_valid      (commit_valid),
        .commit_rd         (commit_rd),
        .commit_prd        (commit_prd),
        .flush             (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                     v;
        logic                     rdv;
        logic [PHYS_REG_BITS-1:0] prd;
        logic [PHYS_REG_BITS-1:0] old;
        logic [PHYS_REG_BITS-1:0] s1;
        logic [PHYS_REG_BITS-1:0] s2;
    } exp_slot_t;

    exp_slot_t sb   [$];
    exp_slot_t pend [$];
    exp_slot_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, int slot, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s slot%0d: got %0d expected %0d", name, slot, act, exp);
        end
    endtask

    // Monitor: a downstream transfer happens at the next edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && (|ren_valid) && ren_ready) begin
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", s, 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ren_valid", s, 32'(ren_valid[s]), 32'(mon_e.v));
                    if (mon_e.v) begin
                        chk("ren_rd_valid", s, 32'(ren_rd_valid[s]), 32'(mon_e.rdv));
                        chk("ren_prs1", s, 32'(ren_prs1[s]), 32'(mon_e.s1));
                        chk("ren_prs2", s, 32'(ren_prs2[s]), 32'(mon_e.s2));
                        if (mon_e.rdv) begin
                            chk("ren_prd", s, 32'(ren_prd[s]), 32'(mon_e.prd));
                            chk("ren_old_prd", s, 32'(ren_old_prd[s]), 32'(mon_e.old));
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        dec_valid        = '0;
        dec_rd_valid     = '0;
        fl_alloc_success = '0;
        commit_valid     = '0;
        flush            = 1'b0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            dec_rd[s] = '0; dec_rs1[s] = '0; dec_rs2[s] = '0;
            fl_alloc_phys_reg[s] = '0;
        end
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            commit_rd[k] = '0; commit_prd[k] = '0;
        end
    endtask

    task automatic slot(int s, bit rdv, int rd, int rs1, int rs2, int grant, bit succ);
        dec_valid[s]         = 1'b1;
        dec_rd_valid[s]      = rdv;
        dec_rd[s]            = ARCH_REG_BITS'(rd);
        dec_rs1[s]           = ARCH_REG_BITS'(rs1);
        dec_rs2[s]           = ARCH_REG_BITS'(rs2);
        fl_alloc_phys_reg[s] = PHYS_REG_BITS'(grant);
        fl_alloc_success[s]  = succ;
    endtask

    task automatic commit(int k, int rd, int prd);
        commit_valid[k] = 1'b1;
        commit_rd[k]    = ARCH_REG_BITS'(rd);
        commit_prd[k]   = PHYS_REG_BITS'(prd);
    endtask

    task automatic expect_slot(bit v, bit rdv, int prd, int old, int s1, int s2);
        exp_slot_t e;
        e.v   = v;
        e.rdv = rdv;
        e.prd = PHYS_REG_BITS'(prd);
        e.old = PHYS_REG_BITS'(old);
        e.s1  = PHYS_REG_BITS'(s1);
        e.s2  = PHYS_REG_BITS'(s2);
        pend.push_back(e);
    endtask

    // One decode cycle: check handshake, queue expectations if accepted.
    task automatic cycle(string tag, bit exp_ready, logic [ISSUE_WIDTH-1:0] exp_alloc);
        @(negedge clk);
        chk({tag, "_dec_ready"}, 0, 32'(dec_ready), 32'(exp_ready));
        chk({tag, "_fl_alloc_valid"}, 0, 32'(fl_alloc_valid), 32'(exp_alloc));
        if (exp_ready && dec_valid != '0) begin
            while (pend.size() > 0) sb.push_back(pend.pop_front());
        end
        pend.delete();
        $display("[TB] %s: dec_ready=%0b fl_alloc_valid=%b", tag, dec_ready, fl_alloc_valid);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        ren_ready = 1'b1;
        rst       = 1'b1;
        slot(0, 1, 5, 5, 0, 40, 1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_dec_ready", 0, 32'(dec_ready), 0);
        chk("rst_fl_alloc_valid", 0, 32'(fl_alloc_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_ren_valid", 0, 32'(ren_valid), 0);
        chk("rst_ren_prd", 0, 32'(ren_prd[0]), 0);
        chk("rst_ren_prs1", 1, 32'(ren_prs1[1]), 0);
        $display("[TB] reset: ren_valid=%b", ren_valid);
        @(posedge clk);
        #1;

        // Basic rename after reset.
        slot(0, 1, 5, 5, 0, 40, 1);
        expect_slot(1, 1, 40, 5, 5, 0);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("basic_r5", 1, 2'b01);

        // Intra-group bypass on rs1 and old_prd.
        slot(0, 1, 3, 5, 0, 41, 1);
        slot(1, 1, 3, 3, 5, 42, 1);
        expect_slot(1, 1, 41, 3, 40, 0);
        expect_slot(1, 1, 42, 41, 41, 40);
        cycle("bypass_r3", 1, 2'b11);

        // Map now holds r3->42, r5->40.
        slot(0, 0, 0, 3, 5, 0, 0);
        expect_slot(1, 0, 0, 0, 42, 40);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("lookup_r3", 1, 2'b00);

        // Partial grant: refused, map untouched; retry succeeds.
        slot(0, 1, 10, 10, 0, 43, 1);
        slot(1, 1, 11, 10, 0, 44, 0);
        cycle("partial_grant", 0, 2'b11);
        chk("partial_no_output", 0, 32'(ren_valid), 0);
        slot(0, 1, 10, 10, 0, 45, 1);
        slot(1, 1, 11, 10, 0, 46, 1);
        expect_slot(1, 1, 45, 10, 10, 0);
        expect_slot(1, 1, 46, 11, 45, 0);
        cycle("retry_grant", 1, 2'b11);

        // Backpressure: payload held for 3 cycles, then same-cycle handoff.
        slot(0, 1, 12, 11, 0, 47, 1);
        expect_slot(1, 1, 47, 12, 46, 0);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("stall_a", 1, 2'b01);
        ren_ready = 1'b0;
        slot(0, 1, 13, 12, 0, 48, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_dec_ready", c, 32'(dec_ready), 0);
            chk("stall_fl_alloc_valid", c, 32'(fl_alloc_valid), 0);
            chk("stall_ren_valid", c, 32'(ren_valid), 1);
            chk("stall_ren_prd", c, 32'(ren_prd[0]), 47);
            chk("stall_ren_prs1", c, 32'(ren_prs1[0]), 46);
            $display("[TB] stall cycle %0d: ren_prd=%0d", c, ren_prd[0]);
            @(posedge clk);
            #1;
        end
        ren_ready = 1'b1;
        expect_slot(1, 1, 48, 13, 47, 0);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("stall_b", 1, 2'b01);

        // Rename r7->50, commit it, rename r7->51, flush, look up r7.
        slot(0, 1, 7, 0, 0, 50, 1);
        expect_slot(1, 1, 50, 7, 0, 0);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("r7_to_50", 1, 2'b01);
        slot(0, 1, 7, 7, 0, 51, 1);
        commit(0, 7, 50);
        expect_slot(1, 1, 51, 50, 50, 0);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("r7_to_51_commit50", 1, 2'b01);
        flush = 1'b1;
        slot(0, 1, 8, 0, 0, 53, 1);
        cycle("flush", 0, 2'b00);
        chk("flush_clears_valid", 0, 32'(ren_valid), 0);
        slot(0, 0, 0, 7, 5, 0, 0);
        expect_slot(1, 0, 0, 0, 50, 5);
        expect_slot(0, 0, 0, 0, 0, 0);
        cycle("lookup_after_flush", 1, 2'b00);

        // Same-cycle commit + flush, highest commit slot wins, r0 ignored.
        commit(0, 20, 60);
        commit(1, 20, 61);
        flush = 1'b1;
        cycle("commit_conflict_flush", 0, 2'b00);
        commit(0, 0, 70);
        commit(1, 21, 62);
        flush = 1'b1;
        cycle("commit_r0_flush", 0, 2'b00);
        slot(0, 0, 0, 20, 21, 0, 0);
        slot(1, 0, 0, 0, 7, 0, 0);
        expect_slot(1, 0, 0, 0, 61, 62);
        expect_slot(1, 0, 0, 0, 0, 50);
        cycle("lookup_commits", 1, 2'b00);

        // rd=0 never allocates or remaps; r0 reads phys 0.
        slot(0, 1, 0, 0, 0, 0, 0);
        slot(1, 1, 9, 0, 0, 52, 1);
        expect_slot(1, 0, 0, 0, 0, 0);
        expect_slot(1, 1, 52, 9, 0, 0);
        cycle("rd_zero", 1, 2'b10);

        repeat (3) @(posedge clk);
        #1;

        // Reset dominates accept, commit and flush.
        rst = 1'b1;
        slot(0, 1, 7, 0, 0, 54, 1);
        commit(0, 7, 80);
        flush = 1'b1;
        @(negedge clk);
        chk("rst_dom_dec_ready", 0, 32'(dec_ready), 0);
        chk("rst_dom_fl_alloc_valid", 0, 32'(fl_alloc_valid), 0);
        $display("[TB] reset_dominance: dec_ready=%0b", dec_ready);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        chk("rst_dom_ren_valid", 0, 32'(ren_valid), 0);
        slot(0, 0, 0, 7, 9, 0, 0);
        slot(1, 0, 0, 3, 20, 0, 0);
        expect_slot(1, 0, 0, 0, 7, 9);
        expect_slot(1, 0, 0, 0, 3, 20);
        cycle("lookup_after_reset", 1, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 0, 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
